// File: rtl/conv_sequencer_if.sv
// Operand load and result streams of the conv_sequencer, bundled with the job control lines.
// slave = the sequencer itself; master = whoever loads operands and consumes results.
interface conv_sequencer_if #(
  parameter int N = 3,
  parameter int M = 5
);
  localparam int L  = N + M - 1;
  localparam int IW = $clog2((L > 2) ? L : 2);

  logic          start;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [IW-1:0] out_idx;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, busy, done
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/conv_sequencer.sv
// Sequential 1-D linear convolver: one shared 16x16 MAC, operands streamed in,
// results c[0..N+M-2] streamed out in index order.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_LOAD    | accepting a[0..N-1] then b[0..M-1]
// S_COMPUTE | one product term of c[k] per cycle
// S_OUTPUT  | c[k] presented, waiting for consumer
module conv_sequencer #(
  parameter int N = 3,
  parameter int M = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_sequencer_if.slave bus
);
  localparam int L  = N + M - 1;
  localparam int IW = $clog2((L > 2) ? L : 2);
  localparam int AW = $clog2((N > 2) ? N : 2);
  localparam int BW = $clog2((M > 2) ? M : 2);
  localparam int CW = $clog2(((N + M) > 2) ? (N + M) : 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] k_q, k_d;
  logic [AW-1:0] i_q, i_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          done_q, done_d;

  logic [15:0]   a_q [N];
  logic [15:0]   b_q [M];

  logic [AW-1:0] i_hi;
  logic [BW-1:0] j_sel;
  logic [15:0]   a_sel, b_sel;
  logic [31:0]   prod, acc_sum;

  // First a-index that pairs with a valid b-index for output k.
  function automatic logic [AW-1:0] i_lo_f(input logic [IW-1:0] k);
    int lo;
    lo = int'(k) - (M - 1);
    if (lo < 0) lo = 0;
    return AW'(lo);
  endfunction

  function automatic logic [AW-1:0] i_hi_f(input logic [IW-1:0] k);
    int hi;
    hi = int'(k);
    if (hi > N - 1) hi = N - 1;
    return AW'(hi);
  endfunction

  assign i_hi    = i_hi_f(k_q);
  assign j_sel   = BW'(int'(k_q) - int'(i_q));
  assign a_sel   = a_q[i_q];
  assign b_sel   = b_q[j_sel];
  assign prod    = {16'd0, a_sel} * {16'd0, b_sel};
  assign acc_sum = acc_q + prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      i_q        <= i_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      done_q     <= done_d;
    end
  end

  // Operand storage is rewritten by every job, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && bus.in_valid) begin
      if (cnt_q < CW'(N)) a_q[AW'(cnt_q)] <= bus.in_data;
      else                b_q[BW'(cnt_q - CW'(N))] <= bus.in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    i_d        = i_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (cnt_q == CW'(N + M - 1)) begin
            state_d = S_COMPUTE;
            k_d     = '0;
            i_d     = i_lo_f('0);
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        acc_d = acc_sum;
        if (i_q == i_hi) begin
          state_d    = S_OUTPUT;
          out_data_d = acc_sum;
          out_idx_d  = k_q;
        end else begin
          i_d = i_q + AW'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          if (k_q == IW'(L - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_COMPUTE;
            k_d     = k_q + IW'(1);
            i_d     = i_lo_f(k_q + IW'(1));
            acc_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs come straight from registers: no path from out_ready/in_valid.
  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequential, resource-shared replacement for the fully combinational 1-D convolver: computes the full linear convolution of an N-tap signal `a` with an M-tap signal `b` using a single 16x16 multiplier and 32-bit accumulator. Operands are loaded as a valid/ready stream and results are emitted one per handshake, in index order 0..N+M-2. The block sits between the microprocessor's data bus (load side) and any result consumer (output side). Throughput is traded for area: one MAC per clock.

## Interface
- `N`, 3, length of operand `a` (>=1)
- `M`, 5, length of operand `b` (>=1)
- Derived: `L = N+M-1` outputs; `IW = clog2(max(L,2))` index width

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `start`  in  1  begin a job; sampled only in IDLE
- `in_valid`  in  1  operand beat valid
- `in_data`  in  16  unsigned operand; order a[0..N-1] then b[0..M-1]
- `in_ready`  out  1  operand accepted when `in_valid && in_ready`
- `out_valid`  out  1  result valid
- `out_data`  out  32  result c[k] = sum a[i]*b[k-i], mod 2^32
- `out_idx`  out  IW  k of current result
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse after final result handshake

## Operation
- States: IDLE, LOAD, COMPUTE, OUTPUT.
- IDLE: `in_ready=0`, `out_valid=0`. `start=1` -> LOAD, load counter=0. `start` in any other state is ignored.
- LOAD: `in_ready=1`. Each accepted beat writes a[cnt] (cnt<N) or b[cnt-N]; gaps in `in_valid` simply stall. After beat N+M-1 (0-based) accepted -> COMPUTE with k=0.
- COMPUTE: i runs from i_lo=max(0,k-M+1) to i_hi=min(k,N-1), one term per cycle; acc cleared at entry (first cycle writes acc=a[i_lo]*b[k-i_lo]), thereafter acc += a[i]*b[k-i]. After i_hi term -> OUTPUT, latching acc to `out_data`, k to `out_idx`.
- OUTPUT: `out_valid=1`; `out_data`/`out_idx` held stable until handshake. On handshake: if k=L-1 -> IDLE with `done=1` that cycle; else k++ -> COMPUTE.
- Arithmetic: unsigned; 32-bit product; accumulation wraps modulo 2^32, no saturation or flag.
- Operand registers are not reset (contents undefined after reset); they are fully rewritten every job.
- `start` asserted in the cycle `done` is high is accepted (state is IDLE).

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_idx=0`, `busy=0`, `done=0`; state=IDLE.
- Reset asserted mid-job (any state): abort immediately, all outputs to reset values; no partial result or `done` is produced.
- `start` high at edge t -> `in_ready=1` from t+1.
- Last operand accepted at edge t -> COMPUTE from t+1; result k has T_k=i_hi-i_lo+1 compute cycles; `out_valid` rises at edge (COMPUTE entry + T_k).
- OUTPUT handshake at edge t -> next COMPUTE from t+1; minimum spacing between results = T_k+1 cycles.
- Job length with no stalls: 1 + (N+M) + sum T_k + L cycles; sum T_k = N*M.
- `done` high exactly one cycle, coincident with IDLE; `busy` falls in that cycle.
- No combinational path from `out_ready` or `in_valid` to any output.

## Test plan
- Basic (N=3, M=5): a=1,1,1, b=1,2,3,4,5, out_ready=1 -> out_data 1,3,6,9,12,9,5 with out_idx 0..6; 15 COMPUTE cycles total; one `done` pulse.
- Backpressure: same job, out_ready low 4 cycles on each result -> identical sequence, out_data/out_idx stable while stalled, no result dropped or duplicated.
- Wrap: a=all 0xFFFF, b=all 0xFFFF -> c[0]=0xFFFE0001, c[2]=0xFFFA0003 (3x product mod 2^32), c[6]=0xFFFE0001.
- Load gaps: in_valid toggled 1/0 during LOAD -> same results as basic; in_ready high only in LOAD.
- Reset mid-COMPUTE after c[2] emitted: rst_n low 1 cycle -> all outputs at reset values, busy=0, no done; new job with a=2,0,0, b=1..5 -> 2,4,6,8,10,0,0.
- start held high throughout and re-asserted on done cycle -> ignored while busy; second job starts immediately after done with in_ready=1 next cycle.
